// File: rtl/alu_control_pipe_if.sv
// Handshake and data bundle between the main control decoder, the ALU control pipe and the ALU.
// The master drives decode requests and the slave returns the staged operation code.
interface alu_control_pipe_if #(
    parameter int FUNC_W  = 3,
    parameter int ALUOP_W = 4,
    parameter int OP_W    = 3,
    parameter int CNT_W   = 8
);
    logic               in_valid;
    logic               stall;
    logic               flush;
    logic [FUNC_W-1:0]  func;
    logic [ALUOP_W-1:0] aluOp;
    logic [OP_W-1:0]    operation;
    logic               out_valid;
    logic               illegal;
    logic [CNT_W-1:0]   illegal_count;

    modport master (
        output in_valid, stall, flush, func, aluOp,
        input  operation, out_valid, illegal, illegal_count
    );

    modport slave (
        input  in_valid, stall, flush, func, aluOp,
        output operation, out_valid, illegal, illegal_count
    );
endinterface

// File: rtl/alu_control_pipe.sv
// Pipelined ALU control: decodes aluOp/func into an ALU operation code delivered STAGES cycles
// later, with stall/flush support and a saturating counter of accepted illegal encodings.
module alu_control_pipe #(
    parameter int FUNC_W     = 3,
    parameter int ALUOP_W    = 4,
    parameter int OP_W       = 3,
    parameter int STAGES     = 1,
    parameter int ILLEGAL_OP = 0,
    parameter int CNT_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    alu_control_pipe_if.slave   bus
);

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("alu_control_pipe: STAGES must be in 1..4");
    end
    if (FUNC_W > OP_W) begin : g_bad_func_w
        $error("alu_control_pipe: FUNC_W must not exceed OP_W");
    end
    if (ALUOP_W < 4) begin : g_bad_aluop_w
        $error("alu_control_pipe: ALUOP_W must be at least 4");
    end

    logic              upper_zero;
    logic [OP_W-1:0]   dec_op;
    logic              dec_ill;
    logic              accept;

    logic [STAGES-1:0] stage_valid;
    logic [STAGES-1:0] stage_ill;
    logic [OP_W-1:0]   stage_op [STAGES];
    logic [CNT_W-1:0]  cnt;

    // Any set bit above the 4-bit class field makes the encoding illegal.
    if (ALUOP_W > 4) begin : g_upper
        assign upper_zero = (bus.aluOp[ALUOP_W-1:4] == '0);
    end else begin : g_no_upper
        assign upper_zero = 1'b1;
    end

    always_comb begin
        dec_op  = OP_W'(ILLEGAL_OP);
        dec_ill = 1'b1;
        if (upper_zero) begin
            case (bus.aluOp[3:0])
                4'b0000: begin dec_op = OP_W'(bus.func); dec_ill = 1'b0; end
                4'b0001: begin dec_op = OP_W'(0);        dec_ill = 1'b0; end
                4'b0010: begin dec_op = OP_W'(2);        dec_ill = 1'b0; end
                4'b0011: begin dec_op = OP_W'(3);        dec_ill = 1'b0; end
                4'b0100: begin dec_op = OP_W'(1);        dec_ill = 1'b0; end
                4'b0111: begin dec_op = OP_W'(0);        dec_ill = 1'b0; end
                4'b1000: begin dec_op = OP_W'(0);        dec_ill = 1'b0; end
                4'b1001: begin dec_op = OP_W'(1);        dec_ill = 1'b0; end
                4'b1010: begin dec_op = OP_W'(1);        dec_ill = 1'b0; end
                4'b1011: begin dec_op = OP_W'(6);        dec_ill = 1'b0; end
                4'b1100: begin dec_op = OP_W'(6);        dec_ill = 1'b0; end
                default: begin dec_op = OP_W'(ILLEGAL_OP); dec_ill = 1'b1; end
            endcase
        end
    end

    assign accept = bus.in_valid & ~bus.stall & ~bus.flush;

    // Flush only clears valid bits; stale data is masked at the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= '0;
            stage_ill   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                stage_op[i] <= '0;
            end
        end else if (bus.flush) begin
            stage_valid <= '0;
        end else if (!bus.stall) begin
            stage_valid[0] <= bus.in_valid;
            stage_ill[0]   <= dec_ill;
            stage_op[0]    <= dec_op;
            for (int i = 1; i < STAGES; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                stage_ill[i]   <= stage_ill[i-1];
                stage_op[i]    <= stage_op[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept && dec_ill && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bus.out_valid     = stage_valid[STAGES-1];
    assign bus.operation     = stage_valid[STAGES-1] ? stage_op[STAGES-1] : '0;
    assign bus.illegal       = stage_valid[STAGES-1] & stage_ill[STAGES-1];
    assign bus.illegal_count = cnt;

endmodule
